// File: rtl/vga_mono_filter.sv
// ---------------------------------------------------------------------------
// vga_mono_filter
//
// Registered colour stage between the system core's 6-bit RGB/sync outputs
// and the VGA pins. Computes BT.709 luma with integer weights
// (54*R + 183*G + 18*B) >> 8 and applies a monochrome tint (green, amber,
// white) or passes the colour straight through. Pixels and syncs share a
// fixed 3-cycle latency so they stay aligned on the pins.
//
// The display mode comes from the core's mode request or from a local
// debounced push-button. Requests are collected in a pending register and
// committed only when vsync_in moves to its active level, so a frame is
// never split between two modes.
//
// Ports:
//   clk_vga     in   1  pixel clock
//   rst_n       in   1  synchronous reset, active low
//   r_in/g_in/b_in in 6 colour from core
//   hsync_in    in   1  core hsync
//   vsync_in    in   1  core vsync
//   mode_req    in   2  core mode request: 00 colour, 01 green, 10 amber,
//                      11 white
//   btn_n       in   1  asynchronous mode-cycle button, active low
//   r_out/g_out/b_out out 6 colour to pins
//   hsync_out   out  1  hsync delayed by 3 cycles
//   vsync_out   out  1  vsync delayed by 3 cycles
//   mode_active out  2  mode currently applied by the output mux
//
// Handshake: none. Every input is sampled on every rising clk_vga edge and
// every output is a register updated on every edge; there is no valid or
// ready qualifier on the pixel stream.
//
// Debug: the debouncer state is held in r_db_state (type db_state_t) and
// the pending mode in r_pend for hierarchical observation.
// ---------------------------------------------------------------------------
module vga_mono_filter #(
  parameter int   DEBOUNCE_CYCLES = 571428,
  parameter logic HSYNC_POL       = 1'b0,
  parameter logic VSYNC_POL       = 1'b0
) (
  input  logic       clk_vga,
  input  logic       rst_n,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [1:0] mode_req,
  input  logic       btn_n,
  output logic [5:0] r_out,
  output logic [5:0] g_out,
  output logic [5:0] b_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [1:0] mode_active
);

  // Counter must hold DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] MODE_COLOUR = 2'b00;
  localparam logic [1:0] MODE_GREEN  = 2'b01;
  localparam logic [1:0] MODE_AMBER  = 2'b10;
  localparam logic [1:0] MODE_WHITE  = 2'b11;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  // -------------------------------------------------------------------------
  // Pipeline stage 1: weighted products plus raw colour and syncs
  // -------------------------------------------------------------------------
  logic [13:0] r_s1_pr;
  logic [13:0] r_s1_pg;
  logic [13:0] r_s1_pb;
  logic [5:0]  r_s1_r;
  logic [5:0]  r_s1_g;
  logic [5:0]  r_s1_b;
  logic        r_s1_hs;
  logic        r_s1_vs;

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_s1_pr <= '0;
      r_s1_pg <= '0;
      r_s1_pb <= '0;
      r_s1_r  <= '0;
      r_s1_g  <= '0;
      r_s1_b  <= '0;
      r_s1_hs <= ~HSYNC_POL;
      r_s1_vs <= ~VSYNC_POL;
    end else begin
      r_s1_pr <= 14'(r_in) * 14'd54;
      r_s1_pg <= 14'(g_in) * 14'd183;
      r_s1_pb <= 14'(b_in) * 14'd18;
      r_s1_r  <= r_in;
      r_s1_g  <= g_in;
      r_s1_b  <= b_in;
      r_s1_hs <= hsync_in;
      r_s1_vs <= vsync_in;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline stage 2: luma. Weights sum to 255, so the largest sum is
  // 255*63 = 16065 and Y tops out at 62: six bits always suffice.
  // -------------------------------------------------------------------------
  logic [15:0] w_sum;
  logic [5:0]  w_y;

  assign w_sum = 16'(r_s1_pr) + 16'(r_s1_pg) + 16'(r_s1_pb);
  assign w_y   = 6'(w_sum >> 8);

  logic [5:0] r_s2_y;
  logic [5:0] r_s2_r;
  logic [5:0] r_s2_g;
  logic [5:0] r_s2_b;
  logic       r_s2_hs;
  logic       r_s2_vs;

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_s2_y  <= '0;
      r_s2_r  <= '0;
      r_s2_g  <= '0;
      r_s2_b  <= '0;
      r_s2_hs <= ~HSYNC_POL;
      r_s2_vs <= ~VSYNC_POL;
    end else begin
      r_s2_y  <= w_y;
      r_s2_r  <= r_s1_r;
      r_s2_g  <= r_s1_g;
      r_s2_b  <= r_s1_b;
      r_s2_hs <= r_s1_hs;
      r_s2_vs <= r_s1_vs;
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline stage 3: mode mux driven by the committed mode
  // -------------------------------------------------------------------------
  logic [1:0] r_mode_active;
  logic [5:0] w_mux_r;
  logic [5:0] w_mux_g;
  logic [5:0] w_mux_b;

  always_comb begin
    w_mux_r = r_s2_r;
    w_mux_g = r_s2_g;
    w_mux_b = r_s2_b;
    case (r_mode_active)
      MODE_COLOUR: begin
        w_mux_r = r_s2_r;
        w_mux_g = r_s2_g;
        w_mux_b = r_s2_b;
      end
      MODE_GREEN: begin
        w_mux_r = '0;
        w_mux_g = r_s2_y;
        w_mux_b = '0;
      end
      MODE_AMBER: begin
        w_mux_r = r_s2_y;
        w_mux_g = r_s2_y >> 1;
        w_mux_b = '0;
      end
      MODE_WHITE: begin
        w_mux_r = r_s2_y;
        w_mux_g = r_s2_y;
        w_mux_b = r_s2_y;
      end
      default: begin
        w_mux_r = r_s2_r;
        w_mux_g = r_s2_g;
        w_mux_b = r_s2_b;
      end
    endcase
  end

  logic [5:0] r_s3_r;
  logic [5:0] r_s3_g;
  logic [5:0] r_s3_b;
  logic       r_s3_hs;
  logic       r_s3_vs;

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_s3_r  <= '0;
      r_s3_g  <= '0;
      r_s3_b  <= '0;
      r_s3_hs <= ~HSYNC_POL;
      r_s3_vs <= ~VSYNC_POL;
    end else begin
      r_s3_r  <= w_mux_r;
      r_s3_g  <= w_mux_g;
      r_s3_b  <= w_mux_b;
      r_s3_hs <= r_s2_hs;
      r_s3_vs <= r_s2_vs;
    end
  end

  assign r_out     = r_s3_r;
  assign g_out     = r_s3_g;
  assign b_out     = r_s3_b;
  assign hsync_out = r_s3_hs;
  assign vsync_out = r_s3_vs;

  // -------------------------------------------------------------------------
  // Button synchronizer and debouncer
  // -------------------------------------------------------------------------
  logic [1:0] r_btn_sync;
  logic       w_bs;

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_btn_sync <= 2'b11;
    end else begin
      r_btn_sync <= {r_btn_sync[0], btn_n};
    end
  end

  assign w_bs = r_btn_sync[1];

  db_state_t     r_db_state;
  db_state_t     w_db_next;
  logic [CW-1:0] r_db_cnt;
  logic [CW-1:0] w_db_cnt_next;
  logic          w_accept;

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_db_state <= RELEASED;
      r_db_cnt   <= '0;
    end else begin
      r_db_state <= w_db_next;
      r_db_cnt   <= w_db_cnt_next;
    end
  end

  // The counter is compared before it increments, so each wait state lasts
  // DEBOUNCE_CYCLES cycles of a stable level. Accept fires once, on the
  // PRESS_WAIT -> PRESSED transition; holding the button never repeats it.
  always_comb begin
    w_db_next     = r_db_state;
    w_db_cnt_next = r_db_cnt;
    w_accept      = 1'b0;
    case (r_db_state)
      RELEASED: begin
        if (!w_bs) begin
          w_db_next     = PRESS_WAIT;
          w_db_cnt_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (w_bs) begin
          w_db_next = RELEASED;
        end else if (r_db_cnt == CNT_MAX) begin
          w_db_next = PRESSED;
          w_accept  = 1'b1;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (w_bs) begin
          w_db_next     = RELEASE_WAIT;
          w_db_cnt_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!w_bs) begin
          w_db_next = PRESSED;
        end else if (r_db_cnt == CNT_MAX) begin
          w_db_next = RELEASED;
        end else begin
          w_db_cnt_next = r_db_cnt + 1'b1;
        end
      end
      default: begin
        w_db_next     = RELEASED;
        w_db_cnt_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Pending mode and commit at the vsync active edge
  // -------------------------------------------------------------------------
  logic [1:0] r_mreq_prev;
  logic [1:0] r_pend;
  logic       r_vs_prev;
  logic       w_mreq_chg;
  logic       w_vs_edge;

  assign w_mreq_chg = (mode_req != r_mreq_prev);
  assign w_vs_edge  = (vsync_in == VSYNC_POL) && (r_vs_prev != VSYNC_POL);

  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      r_mreq_prev   <= 2'b00;
      r_pend        <= 2'b00;
      r_vs_prev     <= ~VSYNC_POL;
      r_mode_active <= 2'b00;
    end else begin
      r_mreq_prev <= mode_req;
      r_vs_prev   <= vsync_in;
      // A core request outranks a simultaneous button press; the press is
      // dropped rather than applied on top of the request.
      if (w_mreq_chg) begin
        r_pend <= mode_req;
      end else if (w_accept) begin
        r_pend <= r_pend + 2'd1;
      end
      // Commit uses the pend value held before this edge.
      if (w_vs_edge) begin
        r_mode_active <= r_pend;
      end
    end
  end

  assign mode_active = r_mode_active;

endmodule

// File: tb/tb_vga_mono_filter.sv
// ---------------------------------------------------------------------------
// Testbench for vga_mono_filter with DEBOUNCE_CYCLES = 4 and active-low
// syncs. Inputs change 1 time unit after a rising edge; outputs are sampled
// at the same point, i.e. after the edge has settled.
// ---------------------------------------------------------------------------
module tb_vga_mono_filter;

  logic       clk_vga;
  logic       rst_n;
  logic [5:0] r_in;
  logic [5:0] g_in;
  logic [5:0] b_in;
  logic       hsync_in;
  logic       vsync_in;
  logic [1:0] mode_req;
  logic       btn_n;
  logic [5:0] r_out;
  logic [5:0] g_out;
  logic [5:0] b_out;
  logic       hsync_out;
  logic       vsync_out;
  logic [1:0] mode_active;

  int checks;
  int failures;

  vga_mono_filter #(
    .DEBOUNCE_CYCLES(4),
    .HSYNC_POL(1'b0),
    .VSYNC_POL(1'b0)
  ) dut (
    .clk_vga(clk_vga),
    .rst_n(rst_n),
    .r_in(r_in),
    .g_in(g_in),
    .b_in(b_in),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .mode_req(mode_req),
    .btn_n(btn_n),
    .r_out(r_out),
    .g_out(g_out),
    .b_out(b_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .mode_active(mode_active)
  );

  // Clock
  initial clk_vga = 1'b0;
  always #5 clk_vga = ~clk_vga;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic set_pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
    r_in = r;
    g_in = g;
    b_in = b;
  endtask

  // One vsync pulse (active low). The commit edge is the first tick.
  task automatic vsync_pulse();
    vsync_in = 1'b0;
    tick();
    tick();
    vsync_in = 1'b1;
    repeat (3) tick();
  endtask

  task automatic press(input int hold);
    btn_n = 1'b0;
    repeat (hold) tick();
    btn_n = 1'b1;
    repeat (12) tick();
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    rst_n    = 1'b0;
    set_pix(6'd21, 6'd21, 6'd21);
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    mode_req = 2'b00;
    btn_n    = 1'b1;
    repeat (4) tick();
    checks++;
    if ({r_out, g_out, b_out} !== 18'd0) begin
      failures++;
      $display("FAIL reset_rgb: got %h expected 0", {r_out, g_out, b_out});
    end
    checks++;
    if ({hsync_out, vsync_out} !== 2'b11) begin
      failures++;
      $display("FAIL reset_sync: got %b expected 11", {hsync_out, vsync_out});
    end
    checks++;
    if (mode_active !== 2'b00) begin
      failures++;
      $display("FAIL reset_mode: got %0d expected 0", mode_active);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (r_out !== 6'd0) begin
      failures++;
      $display("FAIL latency_early: got %0d expected 0", r_out);
    end
    tick();
    checks++;
    if ({r_out, g_out, b_out} !== {6'd21, 6'd21, 6'd21}) begin
      failures++;
      $display("FAIL colour_pass: got %0d,%0d,%0d expected 21,21,21", r_out, g_out, b_out);
    end
  endtask

  task automatic test_sync_delay();
    hsync_in = 1'b0;
    tick();
    tick();
    checks++;
    if (hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL hsync_early: got %b expected 1", hsync_out);
    end
    tick();
    checks++;
    if (hsync_out !== 1'b0) begin
      failures++;
      $display("FAIL hsync_delay: got %b expected 0", hsync_out);
    end
    hsync_in = 1'b1;
    repeat (3) tick();
    checks++;
    if (hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL hsync_release: got %b expected 1", hsync_out);
    end
  endtask

  task automatic test_green();
    logic [17:0] vin  [4];
    logic [5:0]  gexp [4];
    vin[0] = {6'd63, 6'd0,  6'd0};   gexp[0] = 6'd13;
    vin[1] = {6'd0,  6'd63, 6'd0};   gexp[1] = 6'd45;
    vin[2] = {6'd0,  6'd0,  6'd63};  gexp[2] = 6'd4;
    vin[3] = {6'd63, 6'd63, 6'd63};  gexp[3] = 6'd62;
    mode_req = 2'b01;
    tick();
    vsync_pulse();
    checks++;
    if (mode_active !== 2'b01) begin
      failures++;
      $display("FAIL green_commit: got %0d expected 1", mode_active);
    end
    for (int i = 0; i < 4; i++) begin
      set_pix(vin[i][17:12], vin[i][11:6], vin[i][5:0]);
      repeat (3) tick();
      checks++;
      if ({r_out, g_out, b_out} !== {6'd0, gexp[i], 6'd0}) begin
        failures++;
        $display("FAIL green_%0d: got %0d,%0d,%0d expected 0,%0d,0", i, r_out, g_out, b_out, gexp[i]);
      end
    end
  endtask

  task automatic test_amber_white();
    mode_req = 2'b10;
    tick();
    vsync_pulse();
    set_pix(6'd63, 6'd63, 6'd63);
    repeat (3) tick();
    checks++;
    if ({r_out, g_out, b_out} !== {6'd62, 6'd31, 6'd0}) begin
      failures++;
      $display("FAIL amber: got %0d,%0d,%0d expected 62,31,0", r_out, g_out, b_out);
    end
    mode_req = 2'b11;
    tick();
    vsync_pulse();
    repeat (3) tick();
    checks++;
    if ({r_out, g_out, b_out} !== {6'd62, 6'd62, 6'd62}) begin
      failures++;
      $display("FAIL white: got %0d,%0d,%0d expected 62,62,62", r_out, g_out, b_out);
    end
  endtask

  task automatic test_midframe();
    mode_req = 2'b00;
    tick();
    vsync_pulse();
    set_pix(6'd10, 6'd20, 6'd30);
    repeat (3) tick();
    mode_req = 2'b11;
    repeat (5) tick();
    checks++;
    if (mode_active !== 2'b00) begin
      failures++;
      $display("FAIL midframe_hold: got %0d expected 0", mode_active);
    end
    checks++;
    if ({r_out, g_out, b_out} !== {6'd10, 6'd20, 6'd30}) begin
      failures++;
      $display("FAIL midframe_colour: got %0d,%0d,%0d expected 10,20,30", r_out, g_out, b_out);
    end
    vsync_in = 1'b0;
    #1;
    checks++;
    if (mode_active !== 2'b00) begin
      failures++;
      $display("FAIL precommit: got %0d expected 0", mode_active);
    end
    tick();
    checks++;
    if (mode_active !== 2'b11) begin
      failures++;
      $display("FAIL commit: got %0d expected 3", mode_active);
    end
    checks++;
    if ({r_out, vsync_out} !== {6'd10, 1'b1}) begin
      failures++;
      $display("FAIL commit_pixel: got r=%0d vs=%b expected r=10 vs=1", r_out, vsync_out);
    end
    tick();
    // (54*10 + 183*20 + 18*30) >> 8 = 4740 >> 8 = 18
    checks++;
    if ({r_out, g_out, b_out, vsync_out} !== {6'd18, 6'd18, 6'd18, 1'b1}) begin
      failures++;
      $display("FAIL white_after: got %0d,%0d,%0d vs=%b expected 18,18,18 vs=1", r_out, g_out, b_out, vsync_out);
    end
    tick();
    checks++;
    if (vsync_out !== 1'b0) begin
      failures++;
      $display("FAIL vsync_delay: got %b expected 0", vsync_out);
    end
    vsync_in = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_debounce();
    mode_req = 2'b00;
    tick();
    vsync_pulse();
    checks++;
    if (mode_active !== 2'b00) begin
      failures++;
      $display("FAIL db_start: got %0d expected 0", mode_active);
    end
    press(2);
    vsync_pulse();
    checks++;
    if (mode_active !== 2'b00) begin
      failures++;
      $display("FAIL glitch: got %0d expected 0", mode_active);
    end
    press(20);
    vsync_pulse();
    checks++;
    if (mode_active !== 2'b01) begin
      failures++;
      $display("FAIL held_press: got %0d expected 1", mode_active);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_mode;
    mode_req = 2'b11;
    tick();
    vsync_pulse();
    checks++;
    if (mode_active !== 2'b11) begin
      failures++;
      $display("FAIL wrap_start: got %0d expected 3", mode_active);
    end
    exp_mode = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_mode = exp_mode + 2'd1;
      press(20);
      vsync_pulse();
      checks++;
      if (mode_active !== exp_mode) begin
        failures++;
        $display("FAIL wrap_%0d: got %0d expected %0d", k, mode_active, exp_mode);
      end
    end
  endtask

  // Button goes low just after edge P0; the synchronizer makes it visible
  // after P2, PRESS_WAIT runs four cycles, and accept is high in the cycle
  // ending at P7. The mode_req change driven after P6 lands on that edge.
  task automatic test_collision();
    mode_req = 2'b00;
    tick();
    btn_n = 1'b0;
    repeat (6) tick();
    mode_req = 2'b10;
    repeat (14) tick();
    btn_n = 1'b1;
    repeat (12) tick();
    vsync_pulse();
    checks++;
    if (mode_active !== 2'b10) begin
      failures++;
      $display("FAIL collision: got %0d expected 2", mode_active);
    end
  endtask

  task automatic test_reset_mid();
    set_pix(6'd40, 6'd40, 6'd40);
    hsync_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({r_out, g_out, b_out, hsync_out, vsync_out, mode_active} !== {18'd0, 2'b11, 2'b00}) begin
      failures++;
      $display("FAIL reset_mid: got rgb=%h hs=%b vs=%b mode=%0d expected 0,1,1,0",
               {r_out, g_out, b_out}, hsync_out, vsync_out, mode_active);
    end
    rst_n    = 1'b1;
    hsync_in = 1'b1;
    repeat (3) tick();
  endtask

  // Sequencer and final report
  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_sync_delay();
    test_green();
    test_amber_white();
    test_midframe();
    test_debounce();
    test_wrap();
    test_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
